jtkiwi_shram: RTL and testbench
===============================

Name: jtkiwi_shram

Overview:
Arbiter for the 8 kB shared RAM between the Kiwi main CPU and the sound/sub CPU. It time-multiplexes a single-port BRAM between the two Z80s. For the sub CPU it produces the mshramen stall signal (sub side computes dev_busy = mshramen & ram_cs); for the main CPU it produces a main_busy wait. It sits directly upstream of the sound CPU block, feeding its ram_dout and mshramen inputs and consuming its ram_addr/ram_din/cpu_rnw/ram_cs outputs.

Parameters:
AW, 13, RAM address width (8 kB).
DW, 8, data width.

Ports:
clk        in   1   system clock
rst_n      in   1   reset, asynchronous, active-low
main_cs    in   1   main CPU shared-RAM select, held for the whole access
main_rnw   in   1   main CPU 1=read, 0=write
main_addr  in   AW  main CPU address
main_dout  in   DW  main CPU write data
main_din   out  DW  read data to main CPU
main_busy  out  1   main CPU wait request
snd_cs     in   1   sub CPU shared-RAM select (ram_cs)
snd_rnw    in   1   sub CPU 1=read (cpu_rnw)
snd_addr   in   AW  sub CPU address (ram_addr)
snd_dout   in   DW  sub CPU write data (ram_din)
snd_din    out  DW  read data to sub CPU (ram_dout)
mshramen   out  1   1 = sub CPU must wait
mem_addr   out  AW  BRAM address
mem_din    out  DW  BRAM write data
mem_we     out  1   BRAM write strobe
mem_dout   in   DW  BRAM read data, 1-cycle latency

Behaviour:
- FSM states: IDLE, MAIN, SND. Encoding in the package. dvalid flag: cleared on grant entry, set on the second grant cycle.
- IDLE: if only main_cs, go to MAIN. If only snd_cs, go to SND. If both, grant the side not served last (last_main flag). After reset last_main=0, so main wins the first tie.
- MAIN/SND: mem_addr and mem_din are muxed from the granted side. mem_we = ~rnw of the granted side, for the first grant cycle only (exactly one write pulse per access). Second cycle onward: dvalid=1, and the granted *_din register loads mem_dout every cycle while dvalid.
- Stay in the grant state while its cs stays high. On cs low, return to IDLE next cycle and update last_main. No back-to-back grant without passing IDLE, which gives a 1-cycle turnaround.
- cs dropped before dvalid: abandon the access and go to IDLE. A write already strobed stands. The *_din of that side is not updated.
- mshramen = ~(state==SND & dvalid), registered so it is aligned with snd_din. The sub CPU is released only when its read data is valid.
- main_busy = main_cs & ~(state==MAIN & dvalid), combinational.
- A request from the other side during a grant is held pending. It is served on the next IDLE arbitration, so there is no starvation; worst-case wait is one full access plus 1 cycle.
- Reset (async, any state): state=IDLE, dvalid=0, last_main=0, mem_we=0, mem_addr=0, mem_din=0, main_din=0, snd_din=0, mshramen=1. main_busy follows main_cs.
- Read latency from cs rise with no contention: 2 cycles (IDLE→grant, grant→dvalid). The data register is valid on the 3rd edge.
- Address/rnw changes while cs is held: the new address is presented combinationally, and data follows 1 cycle later. The write strobe does not repeat.

Decomposition:
- jtkiwi_pkg: state localparams (ST_IDLE=2'd0, ST_MAIN=2'd1, ST_SND=2'd2) and the AW/DW defaults.
- Single module, no sub-module. The BRAM (jtframe_ram) is instantiated by the parent, not here.

Test Plan:
- Main read only: preload addr 0x0123=0xA5, main_cs rises with rnw=1 → main_busy high for 2 cycles, main_din=0xA5 on the 3rd edge, mem_we never high.
- Sub write: snd_cs, rnw=0, addr 0x1FFF, data 0x3C → mem_we high exactly 1 cycle with mem_addr=0x1FFF and mem_din=0x3C. mshramen drops 2 cycles after grant. A following read returns 0x3C.
- Simultaneous requests after reset → main granted first. The sub is held with mshramen=1 until main_cs falls, then granted after 1 IDLE cycle. On the next tie, the sub wins.
- Sub cs pulse of 1 cycle (abandon) → FSM returns to IDLE, snd_din unchanged, mshramen stays 1.
- rst_n asserted during a MAIN write cycle → mem_we=0 immediately (asynchronous), state=IDLE, mshramen=1, all *_din=0.
- Long main hold (main_cs high 50 cycles) with snd_cs pending → sub granted on the 2nd cycle after main_cs falls, and snd_din is correct.

Source files
------------

// File: rtl/jtkiwi_pkg.sv
// rtl/jtkiwi_pkg.sv - shared-RAM arbiter types and default widths
package jtkiwi_pkg;

    localparam int SHRAM_AW = 13;
    localparam int SHRAM_DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAIN = 2'd1,
        ST_SND  = 2'd2
    } state_t;

endpackage

// File: rtl/jtkiwi_shram_if.sv
// rtl/jtkiwi_shram_if.sv - CPU-side and BRAM-side buses of the shared-RAM arbiter
interface jtkiwi_shram_if #(
    parameter int AW = jtkiwi_pkg::SHRAM_AW,
    parameter int DW = jtkiwi_pkg::SHRAM_DW
);
    logic          main_cs;
    logic          main_rnw;
    logic [AW-1:0] main_addr;
    logic [DW-1:0] main_dout;
    logic [DW-1:0] main_din;
    logic          main_busy;

    logic          snd_cs;
    logic          snd_rnw;
    logic [AW-1:0] snd_addr;
    logic [DW-1:0] snd_dout;
    logic [DW-1:0] snd_din;
    logic          mshramen;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic [DW-1:0] mem_dout;

    modport master (
        output main_cs, main_rnw, main_addr, main_dout,
        input  main_din, main_busy,
        output snd_cs, snd_rnw, snd_addr, snd_dout,
        input  snd_din, mshramen,
        input  mem_addr, mem_din, mem_we,
        output mem_dout
    );

    modport slave (
        input  main_cs, main_rnw, main_addr, main_dout,
        output main_din, main_busy,
        input  snd_cs, snd_rnw, snd_addr, snd_dout,
        output snd_din, mshramen,
        output mem_addr, mem_din, mem_we,
        input  mem_dout
    );

endinterface

// File: rtl/jtkiwi_shram.sv
// rtl/jtkiwi_shram.sv - time-multiplexes one BRAM port between the main and sound Z80s
module jtkiwi_shram
    import jtkiwi_pkg::*;
#(
    parameter int AW = SHRAM_AW,
    parameter int DW = SHRAM_DW
) (
    input  logic clk,
    input  logic rst_n,
    jtkiwi_shram_if.slave bus
);

    state_t state, state_nx;
    logic   dvalid, dvalid_nx;
    logic   last_main, last_main_nx;
    logic   gnt_main, gnt_snd;
    logic   gnt_cs, gnt_rnw;

    assign gnt_main = (state == ST_MAIN);
    assign gnt_snd  = (state == ST_SND);

    always_comb begin
        state_nx     = state;
        dvalid_nx    = 1'b0;
        last_main_nx = last_main;
        case (state)
            ST_IDLE: begin
                if (bus.main_cs && bus.snd_cs)
                    state_nx = last_main ? ST_SND : ST_MAIN;
                else if (bus.main_cs)
                    state_nx = ST_MAIN;
                else if (bus.snd_cs)
                    state_nx = ST_SND;
            end
            ST_MAIN: begin
                if (bus.main_cs) begin
                    dvalid_nx = 1'b1;
                end else begin
                    state_nx     = ST_IDLE;
                    last_main_nx = 1'b1;
                end
            end
            ST_SND: begin
                if (bus.snd_cs) begin
                    dvalid_nx = 1'b1;
                end else begin
                    state_nx     = ST_IDLE;
                    last_main_nx = 1'b0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_addr = '0;
        bus.mem_din  = '0;
        gnt_cs       = 1'b0;
        gnt_rnw      = 1'b1;
        if (gnt_main) begin
            bus.mem_addr = bus.main_addr;
            bus.mem_din  = bus.main_dout;
            gnt_cs       = bus.main_cs;
            gnt_rnw      = bus.main_rnw;
        end else if (gnt_snd) begin
            bus.mem_addr = bus.snd_addr;
            bus.mem_din  = bus.snd_dout;
            gnt_cs       = bus.snd_cs;
            gnt_rnw      = bus.snd_rnw;
        end
    end

    // Single write pulse: only in the first grant cycle, and only if the access was not abandoned
    assign bus.mem_we    = gnt_cs & ~gnt_rnw & ~dvalid;
    assign bus.main_busy = bus.main_cs & ~(gnt_main & dvalid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            dvalid       <= 1'b0;
            last_main    <= 1'b0;
            bus.mshramen <= 1'b1;
            bus.main_din <= '0;
            bus.snd_din  <= '0;
        end else begin
            state        <= state_nx;
            dvalid       <= dvalid_nx;
            last_main    <= last_main_nx;
            bus.mshramen <= ~(gnt_snd & dvalid);
            if (gnt_main && dvalid)
                bus.main_din <= bus.mem_dout;
            if (gnt_snd && dvalid)
                bus.snd_din <= bus.mem_dout;
        end
    end

endmodule

// File: tb/tb_jtkiwi_shram.sv
// tb/tb_jtkiwi_shram.sv - directed self-checking bench for the shared-RAM arbiter
module tb_jtkiwi_shram;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic preload = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] mem [0:8191];

    jtkiwi_shram_if bus ();

    jtkiwi_shram dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload)
            mem[13'h0123] <= 8'hA5;
        else if (bus.mem_we)
            mem[bus.mem_addr] <= bus.mem_din;
        bus.mem_dout <= mem[bus.mem_addr];
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.main_cs   = 1'b0;
        bus.main_rnw  = 1'b1;
        bus.main_addr = '0;
        bus.main_dout = '0;
        bus.snd_cs    = 1'b0;
        bus.snd_rnw   = 1'b1;
        bus.snd_addr  = '0;
        bus.snd_dout  = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst_n   = 1'b0;
        preload = 1'b1;
        step();
        step();
        preload = 1'b0;
        rst_n   = 1'b1;
        step();
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n   = 1'b0;
        preload = 1'b1;
        step();
        step();
        checks++; if (bus.mshramen !== 1'b1) begin failures++; $display("FAIL reset_mshramen got=%0b exp=1", bus.mshramen); end
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%0b exp=0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 13'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); end
        checks++; if (bus.main_din !== 8'h00 || bus.snd_din !== 8'h00) begin failures++; $display("FAIL reset_din got=%h/%h exp=00/00", bus.main_din, bus.snd_din); end
        checks++; if (bus.main_busy !== 1'b0) begin failures++; $display("FAIL reset_main_busy got=%0b exp=0", bus.main_busy); end
        preload = 1'b0;
        rst_n   = 1'b1;
        step();
    endtask

    task automatic test_main_read;
        bus.main_rnw  = 1'b1;
        bus.main_addr = 13'h0123;
        bus.main_cs   = 1'b1;
        #1;
        checks++; if (bus.main_busy !== 1'b1 || bus.mem_we !== 1'b0) begin failures++; $display("FAIL mread_cycle1 busy=%0b we=%0b exp busy=1 we=0", bus.main_busy, bus.mem_we); end
        step();
        checks++; if (bus.main_busy !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 13'h0123) begin failures++; $display("FAIL mread_cycle2 busy=%0b we=%0b addr=%h exp 1/0/0123", bus.main_busy, bus.mem_we, bus.mem_addr); end
        step();
        checks++; if (bus.main_busy !== 1'b0 || bus.mem_we !== 1'b0) begin failures++; $display("FAIL mread_cycle3 busy=%0b we=%0b exp busy=0 we=0", bus.main_busy, bus.mem_we); end
        step();
        checks++; if (bus.main_din !== 8'hA5) begin failures++; $display("FAIL mread_data got=%h exp=a5", bus.main_din); end
        bus.main_cs = 1'b0;
        step();
        step();
    endtask

    task automatic test_snd_write;
        bus.snd_rnw  = 1'b0;
        bus.snd_addr = 13'h1FFF;
        bus.snd_dout = 8'h3C;
        bus.snd_cs   = 1'b1;
        #1;
        checks++; if (bus.mshramen !== 1'b1 || bus.mem_we !== 1'b0) begin failures++; $display("FAIL swrite_cycle1 msh=%0b we=%0b exp 1/0", bus.mshramen, bus.mem_we); end
        step();
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 13'h1FFF || bus.mem_din !== 8'h3C) begin failures++; $display("FAIL swrite_strobe we=%0b addr=%h din=%h exp 1/1fff/3c", bus.mem_we, bus.mem_addr, bus.mem_din); end
        step();
        checks++; if (bus.mem_we !== 1'b0 || bus.mshramen !== 1'b1) begin failures++; $display("FAIL swrite_single we=%0b msh=%0b exp 0/1", bus.mem_we, bus.mshramen); end
        step();
        checks++; if (bus.mshramen !== 1'b0) begin failures++; $display("FAIL swrite_release got=%0b exp=0", bus.mshramen); end
        bus.snd_cs = 1'b0;
        step();
        step();
        step();
        bus.snd_rnw = 1'b1;
        bus.snd_cs  = 1'b1;
        step();
        step();
        step();
        checks++; if (bus.snd_din !== 8'h3C || bus.mshramen !== 1'b0) begin failures++; $display("FAIL sread_back din=%h msh=%0b exp 3c/0", bus.snd_din, bus.mshramen); end
        bus.snd_cs = 1'b0;
        step();
        step();
        step();
    endtask

    task automatic test_tie;
        do_reset();
        bus.main_rnw  = 1'b1;
        bus.main_addr = 13'h0123;
        bus.snd_rnw   = 1'b1;
        bus.snd_addr  = 13'h1FFF;
        bus.main_cs   = 1'b1;
        bus.snd_cs    = 1'b1;
        #1;
        checks++; if (bus.main_busy !== 1'b1 || bus.mshramen !== 1'b1) begin failures++; $display("FAIL tie_start busy=%0b msh=%0b exp 1/1", bus.main_busy, bus.mshramen); end
        step();
        checks++; if (bus.mem_addr !== 13'h0123) begin failures++; $display("FAIL tie_main_first addr=%h exp=0123", bus.mem_addr); end
        step();
        step();
        checks++; if (bus.main_din !== 8'hA5 || bus.main_busy !== 1'b0) begin failures++; $display("FAIL tie_main_data din=%h busy=%0b exp a5/0", bus.main_din, bus.main_busy); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.mshramen !== 1'b1) begin failures++; $display("FAIL tie_snd_held cyc=%0d msh=%0b exp=1", i, bus.mshramen); end
        end
        bus.main_cs = 1'b0;
        step();
        bus.main_cs = 1'b1;
        #1;
        checks++; if (bus.mem_addr !== 13'h0000 || bus.mshramen !== 1'b1) begin failures++; $display("FAIL tie_turnaround addr=%h msh=%0b exp 0000/1", bus.mem_addr, bus.mshramen); end
        step();
        checks++; if (bus.mem_addr !== 13'h1FFF || bus.main_busy !== 1'b1) begin failures++; $display("FAIL tie_snd_wins addr=%h busy=%0b exp 1fff/1", bus.mem_addr, bus.main_busy); end
        step();
        step();
        checks++; if (bus.snd_din !== 8'h3C || bus.mshramen !== 1'b0) begin failures++; $display("FAIL tie_snd_data din=%h msh=%0b exp 3c/0", bus.snd_din, bus.mshramen); end
        bus.snd_cs = 1'b0;
        step();
        step();
        checks++; if (bus.mem_addr !== 13'h0123 || bus.main_busy !== 1'b1) begin failures++; $display("FAIL tie_main_again addr=%h busy=%0b exp 0123/1", bus.mem_addr, bus.main_busy); end
        step();
        checks++; if (bus.main_busy !== 1'b0) begin failures++; $display("FAIL tie_main_release busy=%0b exp=0", bus.main_busy); end
        bus.main_cs = 1'b0;
        step();
        step();
    endtask

    task automatic test_abandon;
        bus.snd_rnw  = 1'b0;
        bus.snd_addr = 13'h0123;
        bus.snd_dout = 8'h5A;
        bus.snd_cs   = 1'b1;
        step();
        bus.snd_cs = 1'b0;
        #1;
        checks++; if (bus.mem_we !== 1'b0 || bus.mshramen !== 1'b1) begin failures++; $display("FAIL abandon_grant we=%0b msh=%0b exp 0/1", bus.mem_we, bus.mshramen); end
        step();
        checks++; if (bus.mshramen !== 1'b1 || bus.mem_addr !== 13'h0000) begin failures++; $display("FAIL abandon_idle msh=%0b addr=%h exp 1/0000", bus.mshramen, bus.mem_addr); end
        step();
        checks++; if (bus.mshramen !== 1'b1 || bus.snd_din !== 8'h3C) begin failures++; $display("FAIL abandon_din msh=%0b din=%h exp 1/3c", bus.mshramen, bus.snd_din); end
        bus.main_rnw  = 1'b1;
        bus.main_addr = 13'h0123;
        bus.main_cs   = 1'b1;
        step();
        step();
        step();
        checks++; if (bus.main_din !== 8'hA5) begin failures++; $display("FAIL abandon_no_write got=%h exp=a5", bus.main_din); end
        bus.main_cs = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_mid_write;
        bus.main_rnw  = 1'b0;
        bus.main_addr = 13'h0042;
        bus.main_dout = 8'h77;
        bus.main_cs   = 1'b1;
        step();
        checks++; if (bus.mem_we !== 1'b1) begin failures++; $display("FAIL rstw_strobe we=%0b exp=1", bus.mem_we); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 13'h0 || bus.mem_din !== 8'h00) begin failures++; $display("FAIL rstw_mem we=%0b addr=%h din=%h exp 0/0000/00", bus.mem_we, bus.mem_addr, bus.mem_din); end
        checks++; if (bus.mshramen !== 1'b1 || bus.main_din !== 8'h00 || bus.snd_din !== 8'h00) begin failures++; $display("FAIL rstw_regs msh=%0b mdin=%h sdin=%h exp 1/00/00", bus.mshramen, bus.main_din, bus.snd_din); end
        checks++; if (bus.main_busy !== 1'b1) begin failures++; $display("FAIL rstw_busy got=%0b exp=1", bus.main_busy); end
        bus.main_cs = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_long_hold;
        bus.main_rnw  = 1'b1;
        bus.main_addr = 13'h0123;
        bus.main_cs   = 1'b1;
        step();
        bus.snd_rnw  = 1'b1;
        bus.snd_addr = 13'h1FFF;
        bus.snd_cs   = 1'b1;
        for (int i = 0; i < 48; i++) begin
            step();
            if (i == 19) begin
                checks++; if (bus.main_din !== 8'hA5) begin failures++; $display("FAIL hold_data_a got=%h exp=a5", bus.main_din); end
                bus.main_addr = 13'h1FFF;
            end
            checks++; if (bus.mshramen !== 1'b1 || bus.mem_we !== 1'b0) begin failures++; $display("FAIL hold_cycle cyc=%0d msh=%0b we=%0b exp 1/0", i, bus.mshramen, bus.mem_we); end
        end
        checks++; if (bus.main_din !== 8'h3C) begin failures++; $display("FAIL hold_addr_change got=%h exp=3c", bus.main_din); end
        bus.main_cs = 1'b0;
        step();
        checks++; if (bus.mem_addr !== 13'h0000 || bus.mshramen !== 1'b1) begin failures++; $display("FAIL hold_idle addr=%h msh=%0b exp 0000/1", bus.mem_addr, bus.mshramen); end
        step();
        checks++; if (bus.mem_addr !== 13'h1FFF || bus.mshramen !== 1'b1) begin failures++; $display("FAIL hold_snd_grant addr=%h msh=%0b exp 1fff/1", bus.mem_addr, bus.mshramen); end
        step();
        step();
        checks++; if (bus.snd_din !== 8'h3C || bus.mshramen !== 1'b0) begin failures++; $display("FAIL hold_snd_data din=%h msh=%0b exp 3c/0", bus.snd_din, bus.mshramen); end
        bus.snd_cs = 1'b0;
        step();
        step();
    endtask

    initial begin
        bus.main_cs   = 1'b0;
        bus.main_rnw  = 1'b1;
        bus.main_addr = '0;
        bus.main_dout = '0;
        bus.snd_cs    = 1'b0;
        bus.snd_rnw   = 1'b1;
        bus.snd_addr  = '0;
        bus.snd_dout  = '0;
        test_reset();
        test_main_read();
        test_snd_write();
        test_tie();
        test_abandon();
        test_reset_mid_write();
        test_long_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
